// File: rtl/etx_pkg.sv
// rtl/etx_pkg.sv - shared types and packet field layout for the eMesh TX arbiter
package etx_pkg;

  localparam int PACKET_W = 103;

  // Packet field slices: {write, datamode, ctrlmode, dstaddr, srcaddr, data}
  localparam int WRITE_BIT = 102;
  localparam int DMODE_HI  = 101;
  localparam int DMODE_LO  = 100;
  localparam int CMODE_HI  = 99;
  localparam int CMODE_LO  = 96;
  localparam int DST_HI    = 95;
  localparam int DST_LO    = 64;
  localparam int SRC_HI    = 63;
  localparam int SRC_LO    = 32;
  localparam int DATA_HI   = 31;
  localparam int DATA_LO   = 0;

  // Grant vector bit positions
  localparam int SRC_RR  = 0;
  localparam int SRC_WR  = 1;
  localparam int SRC_RQ  = 2;
  localparam int NUM_SRC = 3;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/etx_arb_grant.sv
// rtl/etx_arb_grant.sv - eligibility and priority picker, one-hot grant (ETX_ARB_RR_EN adds wr/rq round-robin)
module etx_arb_grant
  import etx_pkg::*;
(
`ifdef ETX_ARB_RR_EN
  input  logic               clk,
  input  logic               reset,
`endif
  input  logic               grant_en,
  input  logic               tx_enable,
  input  logic [NUM_SRC-1:0] nonempty,
  input  logic               rd_wait,
  input  logic               wr_wait,
  output logic [NUM_SRC-1:0] grant
);

  logic [NUM_SRC-1:0] elig;

  // Writes and read responses share the write channel; read requests use the read channel
  always_comb begin
    elig         = '0;
    elig[SRC_RR] = tx_enable & nonempty[SRC_RR] & ~wr_wait;
    elig[SRC_WR] = tx_enable & nonempty[SRC_WR] & ~wr_wait;
    elig[SRC_RQ] = tx_enable & nonempty[SRC_RQ] & ~rd_wait;
  end

`ifdef ETX_ARB_RR_EN
  // rq_first=0 favours writes, 1 favours read requests; read responses always win
  logic rq_first;

  // Pointer moves to the other source after every wr or rq grant
  always_ff @(posedge clk) begin
    if (reset)
      rq_first <= 1'b0;
    else if (grant[SRC_WR])
      rq_first <= 1'b1;
    else if (grant[SRC_RQ])
      rq_first <= 1'b0;
  end

  // Absolute priority for rr, then round-robin between wr and rq skipping ineligible ones
  always_comb begin
    grant = '0;
    if (grant_en) begin
      if (elig[SRC_RR])
        grant[SRC_RR] = 1'b1;
      else if (!rq_first) begin
        if (elig[SRC_WR])      grant[SRC_WR] = 1'b1;
        else if (elig[SRC_RQ]) grant[SRC_RQ] = 1'b1;
      end else begin
        if (elig[SRC_RQ])      grant[SRC_RQ] = 1'b1;
        else if (elig[SRC_WR]) grant[SRC_WR] = 1'b1;
      end
    end
  end
`else
  // Fixed priority rr > wr > rq
  always_comb begin
    grant = '0;
    if (grant_en) begin
      if (elig[SRC_RR])      grant[SRC_RR] = 1'b1;
      else if (elig[SRC_WR]) grant[SRC_WR] = 1'b1;
      else if (elig[SRC_RQ]) grant[SRC_RQ] = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/etx_arb.sv
// rtl/etx_arb.sv - TX eMesh arbiter: three FWFT FIFOs into one registered output (option: ETX_ARB_RR_EN)
module etx_arb
  import etx_pkg::*;
#(
  parameter logic [15:0] C_ACK_TIMEOUT = 16'd1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ecfg_tx_enable,
  input  logic                emwr_empty,
  input  logic [PACKET_W-1:0] emwr_packet,
  output logic                emwr_rd_en,
  input  logic                emrq_empty,
  input  logic [PACKET_W-1:0] emrq_packet,
  output logic                emrq_rd_en,
  input  logic                emrr_empty,
  input  logic [PACKET_W-1:0] emrr_packet,
  output logic                emrr_rd_en,
  input  logic                etx_rd_wait,
  input  logic                etx_wr_wait,
  input  logic                etx_ack,
  output logic                etx_access,
  output logic                etx_write,
  output logic [1:0]          etx_datamode,
  output logic [3:0]          etx_ctrlmode,
  output logic [31:0]         etx_dstaddr,
  output logic [31:0]         etx_srcaddr,
  output logic [31:0]         etx_data,
  output logic                etx_timeout
);

  state_t              state, state_next;
  logic                grant_en;
  logic                any_grant;
  logic [NUM_SRC-1:0]  nonempty;
  logic [NUM_SRC-1:0]  grant;
  logic [PACKET_W-1:0] winner;
  logic [PACKET_W-1:0] pkt_q;
  logic [15:0]         ack_cnt;
  logic                timeout_q;

  // A new grant is possible when the output is free or is being released this cycle;
  // reset suppresses grants so no FIFO is popped while the arbiter is held in reset
  assign grant_en = ~reset & ((state == IDLE) | etx_ack);

  assign nonempty[SRC_RR] = ~emrr_empty;
  assign nonempty[SRC_WR] = ~emwr_empty;
  assign nonempty[SRC_RQ] = ~emrq_empty;

  etx_arb_grant u_grant (
`ifdef ETX_ARB_RR_EN
    .clk       (clk),
    .reset     (reset),
`endif
    .grant_en  (grant_en),
    .tx_enable (ecfg_tx_enable),
    .nonempty  (nonempty),
    .rd_wait   (etx_rd_wait),
    .wr_wait   (etx_wr_wait),
    .grant     (grant)
  );

  assign any_grant  = |grant;
  assign emrr_rd_en = grant[SRC_RR];
  assign emwr_rd_en = grant[SRC_WR];
  assign emrq_rd_en = grant[SRC_RQ];

  // Select the granted FIFO's head word
  always_comb begin
    winner = '0;
    if (grant[SRC_RR])      winner = emrr_packet;
    else if (grant[SRC_WR]) winner = emwr_packet;
    else if (grant[SRC_RQ]) winner = emrq_packet;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: grant enters/stays in HOLD, ack without a new grant returns to IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_grant) state_next = HOLD;
      HOLD: if (etx_ack)   state_next = any_grant ? HOLD : IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Output packet register, loaded only on a grant so fields stay stable until ack
  always_ff @(posedge clk) begin
    if (reset)          pkt_q <= '0;
    else if (any_grant) pkt_q <= winner;
  end

  // Saturating count of un-acked HOLD cycles and the sticky timeout flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if ((state == HOLD) && !etx_ack) begin
      if (ack_cnt != 16'hFFFF)
        ack_cnt <= ack_cnt + 16'd1;
      if (({1'b0, ack_cnt} + 17'd1) >= {1'b0, C_ACK_TIMEOUT})
        timeout_q <= 1'b1;
    end else begin
      ack_cnt <= '0;
    end
  end

  assign etx_access   = (state == HOLD);
  assign etx_timeout  = timeout_q;
  assign etx_write    = pkt_q[WRITE_BIT];
  assign etx_datamode = pkt_q[DMODE_HI:DMODE_LO];
  assign etx_ctrlmode = pkt_q[CMODE_HI:CMODE_LO];
  assign etx_dstaddr  = pkt_q[DST_HI:DST_LO];
  assign etx_srcaddr  = pkt_q[SRC_HI:SRC_LO];
  assign etx_data     = pkt_q[DATA_HI:DATA_LO];

endmodule

// File: tb/tb_etx_arb.sv
// tb/tb_etx_arb.sv - self-checking bench for etx_arb: vector table, directed sequences, random vs reference model
module tb_etx_arb;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         ecfg_tx_enable = 1'b1;
  logic         emwr_empty, emrq_empty, emrr_empty;
  logic [102:0] emwr_packet, emrq_packet, emrr_packet;
  logic         emwr_rd_en, emrq_rd_en, emrr_rd_en;
  logic         etx_rd_wait = 1'b0;
  logic         etx_wr_wait = 1'b0;
  logic         etx_ack = 1'b0;
  logic         etx_access, etx_write, etx_timeout;
  logic [1:0]   etx_datamode;
  logic [3:0]   etx_ctrlmode;
  logic [31:0]  etx_dstaddr, etx_srcaddr, etx_data;

  etx_arb dut (
    .clk(clk), .reset(reset), .ecfg_tx_enable(ecfg_tx_enable),
    .emwr_empty(emwr_empty), .emwr_packet(emwr_packet), .emwr_rd_en(emwr_rd_en),
    .emrq_empty(emrq_empty), .emrq_packet(emrq_packet), .emrq_rd_en(emrq_rd_en),
    .emrr_empty(emrr_empty), .emrr_packet(emrr_packet), .emrr_rd_en(emrr_rd_en),
    .etx_rd_wait(etx_rd_wait), .etx_wr_wait(etx_wr_wait), .etx_ack(etx_ack),
    .etx_access(etx_access), .etx_write(etx_write), .etx_datamode(etx_datamode),
    .etx_ctrlmode(etx_ctrlmode), .etx_dstaddr(etx_dstaddr), .etx_srcaddr(etx_srcaddr),
    .etx_data(etx_data), .etx_timeout(etx_timeout)
  );

  always #5 clk = ~clk;

  // FIFO contents: 0 = read responses, 1 = writes, 2 = read requests
  logic [102:0] q0[$], q1[$], q2[$];
  logic [2:0]   last_rd;
  int           passed = 0;
  int           total  = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [102:0] mk(input int src, input int idx);
    logic [31:0] d;
    logic [7:0]  i8;
    i8 = idx[7:0];
    d  = 32'h8100_0000 | (src << 8) | {24'd0, i8};
    return {(src != 2), i8[1:0], 4'(src), d, 32'h0000_1000 + idx, $urandom};
  endfunction

  task automatic drive_fifos();
    emrr_empty  = (q0.size() == 0);
    emwr_empty  = (q1.size() == 0);
    emrq_empty  = (q2.size() == 0);
    emrr_packet = (q0.size() != 0) ? q0[0] : '0;
    emwr_packet = (q1.size() != 0) ? q1[0] : '0;
    emrq_packet = (q2.size() != 0) ? q2[0] : '0;
  endtask

  task automatic push(input int src, input logic [102:0] p);
    case (src)
      0: q0.push_back(p);
      1: q1.push_back(p);
      default: q2.push_back(p);
    endcase
    drive_fifos();
  endtask

  task automatic clear_fifos();
    q0.delete(); q1.delete(); q2.delete();
    drive_fifos();
  endtask

  // One clock: sample rd_en mid-cycle, pop the FIFOs that were read, settle 1 ns after the edge
  task automatic tick();
    logic [2:0] emp;
    @(negedge clk);
    last_rd = {emrq_rd_en, emwr_rd_en, emrr_rd_en};
    emp     = {emrq_empty, emwr_empty, emrr_empty};
    chk("rd_onehot", ($countones(last_rd) <= 1), 1);
    chk("rd_on_empty", last_rd & emp, 0);
    @(posedge clk);
    #1;
    if (last_rd[0] && q0.size() != 0) void'(q0.pop_front());
    if (last_rd[1] && q1.size() != 0) void'(q1.pop_front());
    if (last_rd[2] && q2.size() != 0) void'(q2.pop_front());
    drive_fifos();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    etx_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [102:0] out_pkt();
    return {etx_write, etx_datamode, etx_ctrlmode, etx_dstaddr, etx_srcaddr, etx_data};
  endfunction

  typedef struct {
    logic [2:0] ne;   // {rq, wr, rr} non-empty
    logic       rdw;
    logic       wrw;
    logic       en;
    logic [2:0] exp;  // expected one-hot {rq, wr, rr} read enable
  } vec_t;

  // Reference model state
  bit           m_held, m_to, m_ptr;
  int           m_hc;
  logic [102:0] m_pkt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[10];
    logic [2:0] ne;
    logic [31:0] exp_dst[12];
    logic [102:0] held;
    int         n, src, cnt[3];

    clear_fifos();

    // 1. Reset behaviour and first-grant latency
    push(0, mk(0, 4));
    do_reset();
    chk("reset_rd_en", last_rd, 3'b000);
    chk("reset_access", etx_access, 0);
    chk("reset_fields", out_pkt(), 0);
    chk("reset_timeout", etx_timeout, 0);
    tick();
    chk("t1_rr_rd_en", last_rd, 3'b001);
    chk("t1_access", etx_access, 1);
    chk("t1_dstaddr", etx_dstaddr, 32'h8100_0004);
    tick();
    chk("t1_rd_en_once", last_rd, 3'b000);
    chk("t1_access_held", etx_access, 1);
    etx_ack = 1'b1; tick(); etx_ack = 1'b0;
    chk("t1_idle", etx_access, 0);

    // Table of single grant decisions from a freshly reset arbiter
    tbl[0] = '{3'b111, 0, 0, 1, 3'b001};
    tbl[1] = '{3'b110, 0, 0, 1, 3'b010};
    tbl[2] = '{3'b100, 0, 0, 1, 3'b100};
    tbl[3] = '{3'b111, 0, 1, 1, 3'b100};
    tbl[4] = '{3'b111, 1, 1, 1, 3'b000};
    tbl[5] = '{3'b111, 0, 0, 0, 3'b000};
    tbl[6] = '{3'b011, 0, 1, 1, 3'b000};
    tbl[7] = '{3'b101, 1, 0, 1, 3'b001};
    tbl[8] = '{3'b000, 0, 0, 1, 3'b000};
    tbl[9] = '{3'b110, 0, 1, 1, 3'b100};
    for (int v = 0; v < 10; v++) begin
      clear_fifos();
      ne = tbl[v].ne;
      for (int s = 0; s < 3; s++) if (ne[s]) push(s, mk(s, 0));
      etx_rd_wait = tbl[v].rdw;
      etx_wr_wait = tbl[v].wrw;
      ecfg_tx_enable = tbl[v].en;
      do_reset();
      tick();
      chk($sformatf("tbl%0d_rd_en", v), last_rd, tbl[v].exp);
      chk($sformatf("tbl%0d_access", v), etx_access, (tbl[v].exp != 0));
      for (int s = 0; s < 3; s++)
        if (tbl[v].exp[s]) chk($sformatf("tbl%0d_dst", v), etx_dstaddr, 32'h8100_0000 | (s << 8));
    end
    etx_rd_wait = 1'b0; etx_wr_wait = 1'b0; ecfg_tx_enable = 1'b1;

    // 2. Four entries per FIFO, ack in each access cycle: grant order
    clear_fifos();
    for (int s = 0; s < 3; s++) for (int i = 0; i < 4; i++) push(s, mk(s, i));
    cnt = '{0, 0, 0};
    for (int k = 0; k < 12; k++) begin
`ifdef ETX_ARB_RR_EN
      src = (k < 4) ? 0 : ((k % 2 == 0) ? 1 : 2);
`else
      src = k / 4;
`endif
      exp_dst[k] = 32'h8100_0000 | (src << 8) | cnt[src];
      cnt[src]++;
    end
    do_reset();
    n = 0;
    for (int c = 0; c < 100 && n < 12; c++) begin
      tick();
      if (etx_access) begin
        chk($sformatf("t2_order%0d", n), etx_dstaddr, exp_dst[n]);
        n++;
        etx_ack = 1'b1;
      end else etx_ack = 1'b0;
    end
    chk("t2_count", n, 12);
    etx_ack = 1'b0;
    tick();

    // 3. Read wait blocks the only read request until it drops
    clear_fifos();
    etx_rd_wait = 1'b1;
    push(2, mk(2, 7));
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_blocked_rd", last_rd, 3'b000);
      chk("t3_blocked_access", etx_access, 0);
    end
    etx_rd_wait = 1'b0;
    tick();
    chk("t3_grant_rd", last_rd, 3'b100);
    chk("t3_grant_access", etx_access, 1);
    etx_ack = 1'b1; tick(); etx_ack = 1'b0;

    // 4. Ack timeout
    clear_fifos();
    push(1, mk(1, 3));
    do_reset();
    tick();
    chk("t4_access", etx_access, 1);
    held = out_pkt();
    for (int i = 0; i < 1021; i++) tick();
    chk("t4_timeout_early", etx_timeout, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("t4_timeout_set", etx_timeout, 1);
    chk("t4_data_kept", out_pkt(), held);
    chk("t4_access_kept", etx_access, 1);
    etx_ack = 1'b1; tick(); etx_ack = 1'b0;
    chk("t4_access_drop", etx_access, 0);
    tick(); tick();
    chk("t4_timeout_sticky", etx_timeout, 1);
    do_reset();
    chk("t4_timeout_reset", etx_timeout, 0);

    // 5. Back-to-back with ack tied high
    clear_fifos();
    for (int i = 0; i < 8; i++) push(1, mk(1, i));
    do_reset();
    etx_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t5_access%0d", i), etx_access, 1);
      chk($sformatf("t5_dst%0d", i), etx_dstaddr, 32'h8100_0100 | i);
    end
    tick();
    chk("t5_drain", etx_access, 0);
    etx_ack = 1'b0;

    // 6. Enable dropped during HOLD, then reset during HOLD
    clear_fifos();
    push(1, mk(1, 0)); push(1, mk(1, 1));
    do_reset();
    tick();
    chk("t6_hold", etx_access, 1);
    ecfg_tx_enable = 1'b0;
    tick();
    chk("t6_hold_disabled", etx_access, 1);
    etx_ack = 1'b1; tick(); etx_ack = 1'b0;
    chk("t6_complete", etx_access, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_grant_rd", last_rd, 3'b000);
      chk("t6_no_grant_access", etx_access, 0);
    end
    ecfg_tx_enable = 1'b1;
    tick();
    chk("t6_regrant", etx_dstaddr, 32'h8100_0101);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_reset_hold", etx_access, 0);

    // Random traffic against the reference model
    clear_fifos();
    do_reset();
    m_held = 0; m_to = 0; m_ptr = 0; m_hc = 0; m_pkt = '0;
    for (int c = 0; c < 1500; c++) begin
      bit el0, el1, el2, can;
      int win;
      logic [102:0] wpkt;
      etx_ack        = ($urandom_range(0, 1) == 1);
      etx_rd_wait    = ($urandom_range(0, 3) == 0);
      etx_wr_wait    = ($urandom_range(0, 3) == 0);
      ecfg_tx_enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 4) begin
        src = $urandom_range(0, 2);
        if ((src == 0 && q0.size() < 4) || (src == 1 && q1.size() < 4) || (src == 2 && q2.size() < 4))
          push(src, mk(src, c));
      end
      can = !m_held || etx_ack;
      el0 = ecfg_tx_enable && q0.size() > 0 && !etx_wr_wait;
      el1 = ecfg_tx_enable && q1.size() > 0 && !etx_wr_wait;
      el2 = ecfg_tx_enable && q2.size() > 0 && !etx_rd_wait;
      win = -1;
      if (can) begin
        if (el0) win = 0;
`ifdef ETX_ARB_RR_EN
        else if (!m_ptr) win = el1 ? 1 : (el2 ? 2 : -1);
        else             win = el2 ? 2 : (el1 ? 1 : -1);
`else
        else win = el1 ? 1 : (el2 ? 2 : -1);
`endif
      end
      wpkt = (win == 0) ? q0[0] : (win == 1) ? q1[0] : (win == 2) ? q2[0] : '0;
      tick();
      chk("rnd_rd_en", last_rd, (win >= 0) ? (3'b001 << win) : 3'b000);
      if (m_held && !etx_ack) begin
        m_hc++;
        if (m_hc >= 1023) m_to = 1;
      end else m_hc = 0;
      if (win >= 0) begin
        m_held = 1;
        m_pkt  = wpkt;
        if (win == 1) m_ptr = 1;
        if (win == 2) m_ptr = 0;
      end else if (etx_ack) m_held = 0;
      chk("rnd_access", etx_access, m_held);
      if (m_held) chk("rnd_packet", out_pkt(), m_pkt);
      chk("rnd_timeout", etx_timeout, m_to);
    end
    etx_ack = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
